fc_ctrl: RTL and testbench

Sequencer for the fully-connected unary datapath. Drives `enable`, `toggle` and `mux_select` of the FC datapath so that each fold pass runs exactly one full bitstream period of 2^INWD cycles. Presents each pass's clipped result to downstream through a valid/ready handshake and stalls the datapath while downstream is not ready. Sits between the layer-level scheduler (start/done) and the FC datapath.

---
 rtl/fc_ctrl_pkg.sv | 23 ++
 rtl/fc_ctrl_cnt.sv | 42 ++++
 rtl/fc_ctrl.sv | 139 +++++++++++++
 tb/tb_fc_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fc_ctrl_pkg.sv
// fc_ctrl_pkg: shared types and constants for the FC datapath sequencer.
//   - fc_state_e : sequencer states (idle, bitstream run, result hold)
//   - len_of()   : bitstream period LEN = 2^INWD cycles for a given operand width
//   - fold_idx_t : fold index type for the default fold configuration
package fc_ctrl_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StHold = 2'd2
    } fc_state_e;

    localparam int unsigned DefInwd    = 8;
    localparam int unsigned DefLogFold = 2;
    localparam int unsigned DefLen     = 1 << DefInwd;

    typedef logic [DefLogFold-1:0] fold_idx_t;

    function automatic int unsigned len_of(input int unsigned inwd);
        return 32'd1 << inwd;
    endfunction

endpackage

// File: rtl/fc_ctrl_cnt.sv
// fc_ctrl_cnt: wrapping up-counter with synchronous clear and terminal-count flag.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clr_i      : synchronous clear (wins over inc_i)
//   inc_i      : advance by one, wrapping from Max back to zero
//   cnt_o      : current count
//   tc_o       : count equals Max
module fc_ctrl_cnt #(
    parameter int unsigned      Width = 4,
    parameter logic [Width-1:0] Max   = '1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [Width-1:0] cnt_o,
    output logic             tc_o
);

    logic [Width-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = (cnt_q == Max) ? '0 : cnt_q + Width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;
    assign tc_o  = (cnt_q == Max);

endmodule

// File: rtl/fc_ctrl.sv
// fc_ctrl: sequencer for the fully-connected unary datapath. Each fold pass runs the
// datapath for one full bitstream period (2^INWD cycles), then holds the result on a
// valid/ready handshake until downstream accepts it.
// Optional feature macro: FC_CTRL_FOLD_EN (FOLD passes per start, exposes mux_select_o
// and out_fold_idx_o). Without it a start runs a single pass.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   start_i         : begin a layer evaluation (only honoured while idle)
//   abort_i         : synchronous cancel back to idle, no done pulse
//   busy_o          : not idle
//   done_o          : one-cycle pulse after the final pass result is accepted
//   enable_o        : datapath enable, high while the bitstream runs
//   toggle_o        : marks the last bitstream cycle of a pass
//   mux_select_o    : fold index of the current pass (FC_CTRL_FOLD_EN only)
//   out_valid_o     : pass result is stable on the datapath outputs
//   out_fold_idx_o  : fold index tagged to the presented result (FC_CTRL_FOLD_EN only)
//   out_ready_i     : downstream accepts the result
module fc_ctrl
    import fc_ctrl_pkg::*;
#(
    parameter int unsigned INWD     = 8,
    parameter int unsigned FOLD     = 4,
    parameter int unsigned LOG_FOLD = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start_i,
    input  logic                abort_i,
    output logic                busy_o,
    output logic                done_o,
    output logic                enable_o,
    output logic                toggle_o,
    output logic                out_valid_o,
`ifdef FC_CTRL_FOLD_EN
    output logic [LOG_FOLD-1:0] mux_select_o,
    output logic [LOG_FOLD-1:0] out_fold_idx_o,
`endif
    input  logic                out_ready_i
);

    localparam logic [INWD-1:0] CycMax = INWD'(len_of(INWD) - 1);

    if (FOLD < 2 || (32'd1 << LOG_FOLD) != FOLD) begin : g_bad_cfg
        $error("fc_ctrl: FOLD must be a power of two >= 2 equal to 2**LOG_FOLD");
    end

    fc_state_e state_q, state_d;
    logic      done_q, done_d;
    logic      cyc_tc;
    logic      last_pass;
    logic      accept;

    assign accept = (state_q == StHold) && out_ready_i;

    // Bitstream cycle counter: free-runs through RUN and naturally wraps to zero on the
    // toggle cycle, so each pass starts from zero without an explicit clear.
    fc_ctrl_cnt #(
        .Width (INWD),
        .Max   (CycMax)
    ) u_cyc_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (abort_i || (state_q == StIdle)),
        .inc_i (state_q == StRun),
        .cnt_o (),
        .tc_o  (cyc_tc)
    );

`ifdef FC_CTRL_FOLD_EN
    logic [LOG_FOLD-1:0] fold_cnt;
    logic                fold_tc;

    // Cleared on the final accept too, so the fold index reads zero while idle.
    fc_ctrl_cnt #(
        .Width (LOG_FOLD),
        .Max   (LOG_FOLD'(FOLD - 1))
    ) u_fold_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr_i (abort_i || (state_q == StIdle) || (accept && fold_tc)),
        .inc_i (accept && !fold_tc),
        .cnt_o (fold_cnt),
        .tc_o  (fold_tc)
    );

    assign last_pass      = fold_tc;
    assign mux_select_o   = fold_cnt;
    assign out_fold_idx_o = fold_cnt;
`else
    assign last_pass = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (cyc_tc) begin
                    state_d = StHold;
                end
            end
            StHold: begin
                if (out_ready_i) begin
                    state_d = last_pass ? StIdle : StRun;
                    done_d  = last_pass;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides every transition, including a simultaneous start.
        if (abort_i) begin
            state_d = StIdle;
            done_d  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
        end
    end

    // Outputs decode registered state only; no input reaches an output combinationally.
    assign busy_o      = (state_q != StIdle);
    assign done_o      = done_q;
    assign enable_o    = (state_q == StRun);
    assign toggle_o    = (state_q == StRun) && cyc_tc;
    assign out_valid_o = (state_q == StHold);

endmodule

// File: tb/tb_fc_ctrl.sv
// Self-checking bench for fc_ctrl. A behavioural model, expressed as "passes left" and
// "bitstream cycles left", pushes the expected output vector for every clock into a
// queue; a monitor on the falling edge pops and compares. Directed phases add latency,
// stall, abort, ignored-start and asynchronous-reset checks; a random phase follows.
`timescale 1ns/1ps
module tb_fc_ctrl;

    localparam int unsigned INWD     = 4;
    localparam int unsigned FOLD     = 4;
    localparam int unsigned LOG_FOLD = 2;
    localparam int          LEN      = 1 << INWD;
`ifdef FC_CTRL_FOLD_EN
    localparam int          NPASS    = FOLD;
`else
    localparam int          NPASS    = 1;
`endif

    typedef struct packed {
        logic                busy;
        logic                done;
        logic                enable;
        logic                toggle;
        logic                valid;
        logic [LOG_FOLD-1:0] mux;
        logic [LOG_FOLD-1:0] fidx;
    } obs_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start_i = 1'b0;
    logic abort_i = 1'b0;
    logic out_ready_i = 1'b0;
    logic busy_o, done_o, enable_o, toggle_o, out_valid_o;
    logic [LOG_FOLD-1:0] mux_select_o, out_fold_idx_o;

    int n_checks = 0;
    int n_fail   = 0;

    obs_t exp_q[$];

    // Reference model state
    bit m_busy = 1'b0;
    int m_pass = 0;
    int m_left = 0;
    bit m_done = 1'b0;

    always #5 clk = ~clk;

    fc_ctrl #(
        .INWD     (INWD),
        .FOLD     (FOLD),
        .LOG_FOLD (LOG_FOLD)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .start_i        (start_i),
        .abort_i        (abort_i),
        .busy_o         (busy_o),
        .done_o         (done_o),
        .enable_o       (enable_o),
        .toggle_o       (toggle_o),
        .out_valid_o    (out_valid_o),
`ifdef FC_CTRL_FOLD_EN
        .mux_select_o   (mux_select_o),
        .out_fold_idx_o (out_fold_idx_o),
`endif
        .out_ready_i    (out_ready_i)
    );

`ifndef FC_CTRL_FOLD_EN
    assign mux_select_o   = '0;
    assign out_fold_idx_o = '0;
`endif

    function automatic obs_t sample_dut();
        obs_t o;
        o.busy   = busy_o;
        o.done   = done_o;
        o.enable = enable_o;
        o.toggle = toggle_o;
        o.valid  = out_valid_o;
        o.mux    = mux_select_o;
        o.fidx   = out_fold_idx_o;
        return o;
    endfunction

    function automatic obs_t model_obs();
        obs_t o;
        o.busy   = m_busy;
        o.done   = m_done;
        o.enable = m_busy && (m_left > 0);
        o.toggle = m_busy && (m_left == 1);
        o.valid  = m_busy && (m_left == 0);
        o.mux    = LOG_FOLD'(m_pass);
        o.fidx   = LOG_FOLD'(m_pass);
        return o;
    endfunction

    function automatic void model_reset();
        m_busy = 1'b0;
        m_pass = 0;
        m_left = 0;
        m_done = 1'b0;
    endfunction

    // One clock of the layer-evaluation rules: a start buys NPASS passes of LEN
    // enabled cycles, each followed by a result that waits for out_ready.
    function automatic void model_step(input bit s, input bit a, input bit r);
        m_done = 1'b0;
        if (a) begin
            model_reset();
        end else if (!m_busy) begin
            if (s) begin
                m_busy = 1'b1;
                m_pass = 0;
                m_left = LEN;
            end
        end else if (m_left > 0) begin
            m_left = m_left - 1;
        end else if (r) begin
            if (m_pass == NPASS - 1) begin
                model_reset();
                m_done = 1'b1;
            end else begin
                m_pass = m_pass + 1;
                m_left = LEN;
            end
        end
    endfunction

    task automatic step(input bit s, input bit a, input bit r);
        start_i     = s;
        abort_i     = a;
        out_ready_i = r;
        @(posedge clk);
        if (!rst_n) model_reset();
        else        model_step(s, a, r);
        exp_q.push_back(model_obs());
        #1;
    endtask

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got != want) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, got, want);
        end
    endtask

    // Start a zero-stall evaluation and report edges from start sampling to done.
    task automatic run_clean(output int lat, output int en_cnt, output int tg_cnt);
        bit seen;
        int n;
        seen   = 1'b0;
        n      = 0;
        step(1'b1, 1'b0, 1'b1);
        en_cnt = int'(enable_o);
        tg_cnt = int'(toggle_o);
        while (!seen && n < NPASS * (LEN + 1) + 10) begin
            step(1'b0, 1'b0, 1'b1);
            n++;
            en_cnt += int'(enable_o);
            tg_cnt += int'(toggle_o);
            if (done_o) seen = 1'b1;
        end
        lat = n;
    endtask

    always @(negedge clk) begin
        obs_t e, a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = sample_dut();
            n_checks++;
            if (a !== e) begin
                n_fail++;
                $display("FAIL cycle_outputs t=%0t got busy=%b done=%b en=%b tog=%b vld=%b mux=%0d fidx=%0d, expected busy=%b done=%b en=%b tog=%b vld=%b mux=%0d fidx=%0d",
                         $time, a.busy, a.done, a.enable, a.toggle, a.valid, a.mux, a.fidx,
                         e.busy, e.done, e.enable, e.toggle, e.valid, e.mux, e.fidx);
            end
        end
    end

    initial begin
        int lat, en_cnt, tg_cnt, k, vcnt, dcnt;
        logic [LOG_FOLD-1:0] mux_hold;

        // Reset values
        model_reset();
        step(1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("reset_outputs", int'({busy_o, done_o, enable_o, toggle_o, out_valid_o,
                                     mux_select_o, out_fold_idx_o}), 0);
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0);

        // Zero-stall evaluation: done is the (NPASS*(LEN+1)+1)-th cycle counting the
        // start cycle, i.e. NPASS*(LEN+1) edges after the edge that samples start.
        run_clean(lat, en_cnt, tg_cnt);
        check("done_latency", lat, NPASS * (LEN + 1));
        check("enable_cycles", en_cnt, NPASS * LEN);
        check("toggle_count", tg_cnt, NPASS);
        step(1'b0, 1'b0, 1'b0);

        // Stall in HOLD for 5 extra cycles
        step(1'b1, 1'b0, 1'b0);
        k = 0;
        while (!out_valid_o && k < LEN + 4) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        check("reach_hold", int'(out_valid_o), 1);
        mux_hold = mux_select_o;
        vcnt = int'(out_valid_o && !enable_o);
        repeat (5) begin
            step(1'b0, 1'b0, 1'b0);
            vcnt += int'(out_valid_o && !enable_o);
        end
        check("stall_valid_cycles", vcnt, 6);
        check("stall_mux_stable", int'(mux_select_o), int'(mux_hold));
        k = 0;
        while (busy_o && k < NPASS * (LEN + 1) + 10) begin
            step(1'b0, 1'b0, 1'b1);
            k++;
        end
        check("stall_run_ends", int'(busy_o), 0);

        // Abort mid-run, then a clean evaluation
        step(1'b1, 1'b0, 1'b1);
        repeat (LEN / 2) step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b1);
        check("abort_idle", int'({busy_o, done_o, enable_o, toggle_o, out_valid_o,
                                  mux_select_o}), 0);
        step(1'b1, 1'b1, 1'b1);
        check("abort_beats_start", int'(busy_o), 0);
        run_clean(lat, en_cnt, tg_cnt);
        check("post_abort_latency", lat, NPASS * (LEN + 1));
        step(1'b0, 1'b0, 1'b0);

        // Starts while busy are ignored: exactly one done
        step(1'b1, 1'b0, 1'b1);
        dcnt = 0;
        k = 0;
        while (m_busy && k < NPASS * (LEN + 1) + 10) begin
            step(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 3) != 0));
            dcnt += int'(done_o);
            k++;
        end
        step(1'b0, 1'b0, 1'b0);
        dcnt += int'(done_o);
        check("single_done", dcnt, 1);

        // Asynchronous reset while holding a result
        step(1'b1, 1'b0, 1'b0);
        k = 0;
        while (!out_valid_o && k < LEN + 4) begin
            step(1'b0, 1'b0, 1'b0);
            k++;
        end
        check("hold_before_reset", int'(out_valid_o), 1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        model_reset();
        #1;
        check("async_reset", int'({busy_o, done_o, enable_o, toggle_o, out_valid_o,
                                   mux_select_o, out_fold_idx_o}), 0);
        step(1'b1, 1'b0, 1'b1);
        rst_n = 1'b1;
        run_clean(lat, en_cnt, tg_cnt);
        check("post_reset_latency", lat, NPASS * (LEN + 1));

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 3) != 0));
        end
        step(1'b0, 1'b1, 1'b0);
        #10;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
